// File: rtl/joystick_nav_decoder.sv
`default_nettype none
// ============================================================================
// Module   : joystick_nav_decoder
// Brief    : Two-axis ADC samples to debounced L/R/U/D levels with hysteresis
//            and one-cycle press events. Optional macro JOY_AUTOREPEAT_EN adds
//            auto-repeat events while a direction is held.
// Revision : 1.0 - initial release
// ============================================================================
module joystick_nav_decoder #(
    parameter int ADC_W         = 12,
    parameter int THRESH_LOW    = 1000,
    parameter int THRESH_HIGH   = 3000,
    parameter int HYST          = 200,
    parameter int DEB_CYCLES    = 16,
    parameter int REPEAT_DELAY  = 5000000,
    parameter int REPEAT_PERIOD = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADC_W-1:0] x_axis_in,
    input  logic [ADC_W-1:0] y_axis_in,
    output logic             btn_L_out,
    output logic             btn_R_out,
    output logic             btn_U_out,
    output logic             btn_D_out,
    output logic             evt_L_out,
    output logic             evt_R_out,
    output logic             evt_U_out,
    output logic             evt_D_out
);

    // Thresholds widened to 32 bits so the compares stay unsigned and width-matched.
    localparam logic [31:0] c_low_set   = 32'(THRESH_LOW);
    localparam logic [31:0] c_low_clr   = 32'(THRESH_LOW + HYST);
    localparam logic [31:0] c_high_set  = 32'(THRESH_HIGH);
    localparam logic [31:0] c_high_clr  = 32'(THRESH_HIGH - HYST);

    localparam int                 c_deb_w    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEB_CYCLES - 1);
    localparam logic [c_deb_w-1:0] c_deb_one  = c_deb_w'(1);

`ifdef JOY_AUTOREPEAT_EN
    localparam int                 c_rep_max    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int                 c_rep_w      = (c_rep_max > 1) ? $clog2(c_rep_max) : 1;
    localparam logic [c_rep_w-1:0] c_delay_last = c_rep_w'(REPEAT_DELAY - 1);
    localparam logic [c_rep_w-1:0] c_per_last   = c_rep_w'(REPEAT_PERIOD - 1);
    localparam logic [c_rep_w-1:0] c_rep_one    = c_rep_w'(1);
`endif

    // Direction index: 0=L, 1=R, 2=D, 3=U (low/high pair per axis).
    logic [ADC_W-1:0] w_axis [2];
    logic [3:0]       w_raw;
    logic [3:0]       w_btn;
    logic [3:0]       w_evt;

    assign w_axis[0] = x_axis_in;
    assign w_axis[1] = y_axis_in;

    for (genvar a = 0; a < 2; a++) begin : g_axis
        logic [31:0] w_val;
        logic        r_raw_lo;
        logic        r_raw_hi;

        assign w_val = 32'(w_axis[a]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_raw_lo <= 1'b0;
                r_raw_hi <= 1'b0;
            end else begin
                if (w_val < c_low_set)
                    r_raw_lo <= 1'b1;
                else if (w_val >= c_low_clr)
                    r_raw_lo <= 1'b0;

                if (w_val > c_high_set)
                    r_raw_hi <= 1'b1;
                else if (w_val <= c_high_clr)
                    r_raw_hi <= 1'b0;
            end
        end

        assign w_raw[2*a]   = r_raw_lo;
        assign w_raw[2*a+1] = r_raw_hi;
    end

    for (genvar d = 0; d < 4; d++) begin : g_dir
        logic [c_deb_w-1:0] r_cnt;
        logic               r_stable;
        logic               r_evt;
        logic               w_flip;
        logic               w_rise;
        logic               w_rep_fire;

        // Stable state flips on the cycle the disagreement count would hit DEB_CYCLES.
        assign w_flip = (w_raw[d] != r_stable) && (r_cnt == c_deb_last);
        assign w_rise = w_flip && !r_stable;

`ifdef JOY_AUTOREPEAT_EN
        logic [c_rep_w-1:0] r_rep_cnt;
        logic               r_rep_first;
        logic               w_fall;

        assign w_fall     = w_flip && r_stable;
        assign w_rep_fire = r_stable && !w_fall &&
                            (r_rep_first ? (r_rep_cnt == c_delay_last)
                                         : (r_rep_cnt == c_per_last));

        // Counter idles at zero while released; a release kills any pending repeat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b1;
            end else if (!r_stable || w_fall) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b1;
            end else if (w_rep_fire) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b0;
            end else begin
                r_rep_cnt   <= r_rep_cnt + c_rep_one;
            end
        end
`else
        assign w_rep_fire = 1'b0;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt    <= '0;
                r_stable <= 1'b0;
                r_evt    <= 1'b0;
            end else begin
                if ((w_raw[d] == r_stable) || w_flip)
                    r_cnt <= '0;
                else
                    r_cnt <= r_cnt + c_deb_one;

                if (w_flip)
                    r_stable <= ~r_stable;

                r_evt <= w_rise | w_rep_fire;
            end
        end

        assign w_btn[d] = r_stable;
        assign w_evt[d] = r_evt;
    end

    assign btn_L_out = w_btn[0];
    assign btn_R_out = w_btn[1];
    assign btn_D_out = w_btn[2];
    assign btn_U_out = w_btn[3];
    assign evt_L_out = w_evt[0];
    assign evt_R_out = w_evt[1];
    assign evt_D_out = w_evt[2];
    assign evt_U_out = w_evt[3];

endmodule
`default_nettype wire

// File: tb/tb_joystick_nav_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_joystick_nav_decoder
// Brief    : Directed self-checking bench for joystick_nav_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_joystick_nav_decoder;

    localparam int ADC_W = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [ADC_W-1:0] x_axis_in;
    logic [ADC_W-1:0] y_axis_in;
    logic             btn_L_out, btn_R_out, btn_U_out, btn_D_out;
    logic             evt_L_out, evt_R_out, evt_U_out, evt_D_out;
    logic [3:0]       w_btn;
    logic [3:0]       w_evt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Bit order {U, D, R, L}
    assign w_btn = {btn_U_out, btn_D_out, btn_R_out, btn_L_out};
    assign w_evt = {evt_U_out, evt_D_out, evt_R_out, evt_L_out};

    joystick_nav_decoder #(
        .ADC_W         (ADC_W),
        .THRESH_LOW    (1000),
        .THRESH_HIGH   (3000),
        .HYST          (200),
        .DEB_CYCLES    (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (5)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_axis_in (x_axis_in),
        .y_axis_in (y_axis_in),
        .btn_L_out (btn_L_out),
        .btn_R_out (btn_R_out),
        .btn_U_out (btn_U_out),
        .btn_D_out (btn_D_out),
        .evt_L_out (evt_L_out),
        .evt_R_out (evt_R_out),
        .evt_U_out (evt_U_out),
        .evt_D_out (evt_D_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic       sticky;
        logic [3:0] exp_evt;
        logic [3:0] exp_btn;

        rst_n     = 1'b0;
        x_axis_in = 12'd0;
        y_axis_in = 12'd2000;
        tick(3);
        check("rst_btn", w_btn, 4'b0000);
        check("rst_evt", w_evt, 4'b0000);

        // Release reset with x held at 0: raw at edge 1, btn at edge 5.
        rst_n = 1'b1;
        tick(4);
        check("l_pre_btn", w_btn, 4'b0000);
        tick(1);
        check("l_rise_btn", w_btn, 4'b0001);
        check("l_rise_evt", w_evt, 4'b0001);
        tick(1);
        check("l_evt_once", w_evt, 4'b0000);
        check("l_hold_btn", w_btn, 4'b0001);

        x_axis_in = 12'd2000;
        tick(4);
        check("l_rel_pre", w_btn, 4'b0001);
        tick(1);
        check("l_rel_btn", w_btn, 4'b0000);
        check("l_rel_evt", w_evt, 4'b0000);

        // Three-cycle glitch must be rejected.
        x_axis_in = 12'd500;
        tick(3);
        x_axis_in = 12'd2000;
        sticky = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            sticky = sticky | w_btn[0] | w_evt[0];
        end
        check("glitch3", sticky, 1'b0);

        // Four-cycle pulse is just long enough.
        x_axis_in = 12'd500;
        tick(4);
        x_axis_in = 12'd2000;
        tick(1);
        check("pulse4_btn", w_btn, 4'b0001);
        check("pulse4_evt", w_evt, 4'b0001);
        tick(3);
        check("pulse4_hold", w_btn, 4'b0001);
        tick(1);
        check("pulse4_rel", w_btn, 4'b0000);

        // Exact threshold values do not engage.
        x_axis_in = 12'd1000;
        y_axis_in = 12'd3000;
        tick(8);
        check("thresh_edge", w_btn, 4'b0000);
        x_axis_in = 12'd2000;
        y_axis_in = 12'd2000;
        tick(2);

        // Hysteresis on R.
        x_axis_in = 12'd3500;
        tick(5);
        check("r_rise_btn", w_btn, 4'b0010);
        check("r_rise_evt", w_evt, 4'b0010);
        x_axis_in = 12'd2900;
        tick(10);
        check("r_band_btn", w_btn, 4'b0010);
        check("r_band_evt", w_evt, 4'b0000);
        x_axis_in = 12'd2800;
        tick(4);
        check("r_rel_pre", w_btn, 4'b0010);
        tick(1);
        check("r_rel_btn", w_btn, 4'b0000);
        check("r_rel_evt", w_evt, 4'b0000);

        // Diagonal U+R together.
        x_axis_in = 12'd3500;
        y_axis_in = 12'd3500;
        tick(4);
        check("diag_pre", w_btn, 4'b0000);
        tick(1);
        check("diag_btn", w_btn, 4'b1010);
        check("diag_evt", w_evt, 4'b1010);
        tick(1);
        check("diag_evt_once", w_evt, 4'b0000);
        x_axis_in = 12'd2000;
        y_axis_in = 12'd2000;
        tick(5);
        check("diag_rel", w_btn, 4'b0000);

        // Hold D: press at t=5, btn falls at t=31 after release at t=26.
        y_axis_in = 12'd100;
        for (int t = 1; t <= 32; t++) begin
            tick(1);
`ifdef JOY_AUTOREPEAT_EN
            exp_evt = (t == 5 || t == 15 || t == 20 || t == 25 || t == 30) ? 4'b0100 : 4'b0000;
`else
            exp_evt = (t == 5) ? 4'b0100 : 4'b0000;
`endif
            exp_btn = (t >= 5 && t <= 30) ? 4'b0100 : 4'b0000;
            check($sformatf("hold_evt_t%0d", t), w_evt, exp_evt);
            if (t == 4 || t == 5 || t == 30 || t == 31)
                check($sformatf("hold_btn_t%0d", t), w_btn, exp_btn);
            if (t == 26)
                y_axis_in = 12'd2000;
        end

        // Release mid-delay: btn falls at press+7, no repeat afterwards.
        y_axis_in = 12'd100;
        for (int t = 1; t <= 22; t++) begin
            tick(1);
            exp_evt = (t == 5) ? 4'b0100 : 4'b0000;
            check($sformatf("early_evt_t%0d", t), w_evt, exp_evt);
            if (t == 11)
                check("early_btn_held", w_btn, 4'b0100);
            if (t == 12)
                check("early_btn_rel", w_btn, 4'b0000);
            if (t == 7)
                y_axis_in = 12'd2000;
        end

        // Reset asserted mid-hold clears outputs at once and stays quiet.
        y_axis_in = 12'd100;
        tick(7);
        check("mid_hold_btn", w_btn, 4'b0100);
        rst_n = 1'b0;
        #1;
        check("async_rst_btn", w_btn, 4'b0000);
        check("async_rst_evt", w_evt, 4'b0000);
        sticky = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            sticky = sticky | (|w_btn) | (|w_evt);
        end
        check("rst_quiet", sticky, 1'b0);
        y_axis_in = 12'd2000;
        tick(1);
        rst_n = 1'b1;
        tick(6);
        check("post_rst_btn", w_btn, 4'b0000);
        check("post_rst_evt", w_evt, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
